// File: rtl/pipo_pkg.sv
// Shared op-code encoding for the pipo_bank channel registers.
package pipo_pkg;

  typedef logic [2:0] op_t;

  localparam int unsigned OpWidth = 3;

  localparam op_t OP_HOLD  = 3'b000;
  localparam op_t OP_LOAD  = 3'b001;
  localparam op_t OP_CLEAR = 3'b010;
  localparam op_t OP_SHL   = 3'b011;
  localparam op_t OP_SHR   = 3'b100;
  localparam op_t OP_INC   = 3'b101;
  localparam op_t OP_DEC   = 3'b110;
  localparam op_t OP_CHAIN = 3'b111;

endpackage

// File: rtl/pipo_lane.sv
// One channel of pipo_bank: a WIDTH-bit register with load/clear/shift/count/chain ops
// plus registered zero and carry/borrow/shift-out flags.
module pipo_lane
  import pipo_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  op_t              op_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [WIDTH-1:0] chain_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             zero_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] dout_d, dout_q;
  logic             zero_d, zero_q;
  logic             cout_d, cout_q;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_diff;

  // The extra MSB of each result is the wrap flag (carry on inc, borrow on dec).
  assign inc_sum  = {1'b0, dout_q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_diff = {1'b0, dout_q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    dout_d = dout_q;
    cout_d = cout_q;
    unique case (op_i)
      OP_HOLD: begin
        dout_d = dout_q;
        cout_d = cout_q;
      end
      OP_LOAD: begin
        dout_d = din_i;
        cout_d = 1'b0;
      end
      OP_CLEAR: begin
        dout_d = '0;
        cout_d = 1'b0;
      end
      OP_SHL: begin
        dout_d = {dout_q[WIDTH-2:0], ser_i};
        cout_d = dout_q[WIDTH-1];
      end
      OP_SHR: begin
        dout_d = {ser_i, dout_q[WIDTH-1:1]};
        cout_d = dout_q[0];
      end
      OP_INC: begin
        dout_d = inc_sum[WIDTH-1:0];
        cout_d = inc_sum[WIDTH];
      end
      OP_DEC: begin
        dout_d = dec_diff[WIDTH-1:0];
        cout_d = dec_diff[WIDTH];
      end
      OP_CHAIN: begin
        dout_d = chain_i;
        cout_d = 1'b0;
      end
    endcase
    zero_d = (dout_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      dout_q <= '0;
      zero_q <= 1'b1;
      cout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      zero_q <= zero_d;
      cout_q <= cout_d;
    end
  end

  assign dout_o = dout_q;
  assign zero_o = zero_q;
  assign cout_o = cout_q;

endmodule

// File: rtl/pipo_bank.sv
// Bank of NUM_CH independent PIPO registers; CHAIN links each lane to the previous one,
// lane 0 chaining from its own din so an all-CHAIN bank forms a delay line.
module pipo_bank
  import pipo_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic [OpWidth*NUM_CH-1:0] op,
  input  logic [WIDTH*NUM_CH-1:0]   din,
  input  logic [NUM_CH-1:0]         ser_in,
  output logic [WIDTH*NUM_CH-1:0]   dout,
  output logic [NUM_CH-1:0]         zero,
  output logic [NUM_CH-1:0]         cout
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic [WIDTH-1:0] chain_in;

    if (i == 0) begin : g_head
      assign chain_in = din[WIDTH-1:0];
    end else begin : g_link
      assign chain_in = dout[WIDTH*(i-1) +: WIDTH];
    end

    pipo_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk_i  (clk),
      .clr_ni (clr_n),
      .op_i   (op_t'(op[OpWidth*i +: OpWidth])),
      .din_i  (din[WIDTH*i +: WIDTH]),
      .chain_i(chain_in),
      .ser_i  (ser_in[i]),
      .dout_o (dout[WIDTH*i +: WIDTH]),
      .zero_o (zero[i]),
      .cout_o (cout[i])
    );
  end

endmodule

// File: tb/tb_pipo_bank.sv
// Self-checking bench for pipo_bank (WIDTH=16, NUM_CH=2): directed vector table,
// then random per-channel ops against an arithmetic reference model.
module tb_pipo_bank;

  localparam int unsigned W  = 16;
  localparam int unsigned NC = 2;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, CLR = 3'd2, SHL = 3'd3;
  localparam logic [2:0] SHR = 3'd4, INC = 3'd5, DEC = 3'd6, CHN = 3'd7;

  logic          clk = 1'b0;
  logic          clr_n;
  logic [5:0]    op;
  logic [31:0]   din;
  logic [1:0]    ser_in;
  logic [31:0]   dout;
  logic [1:0]    zero;
  logic [1:0]    cout;

  int n_checks = 0;
  int n_pass   = 0;

  int m_dout[NC];
  int m_cout[NC];

  typedef struct {
    logic        clr_n;
    logic [5:0]  op;
    logic [31:0] din;
    logic [1:0]  ser;
    logic [31:0] e_dout;
    logic [1:0]  e_zero;
    logic [1:0]  e_cout;
  } vec_t;

  vec_t vecs[19];

  pipo_bank #(
    .WIDTH (W),
    .NUM_CH(NC)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .op    (op),
    .din   (din),
    .ser_in(ser_in),
    .dout  (dout),
    .zero  (zero),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance the reference model by one edge using only pre-edge values.
  task automatic model_step(input logic c_n, input logic [5:0] o, input logic [31:0] d,
                            input logic [1:0] s);
    int nd[NC];
    int nc[NC];
    for (int ch = 0; ch < NC; ch++) begin
      int r;
      int sb;
      int di;
      r  = m_dout[ch];
      sb = int'(s[ch]);
      di = int'(d[16*ch +: 16]);
      nd[ch] = r;
      nc[ch] = m_cout[ch];
      case (o[3*ch +: 3])
        LOAD: begin nd[ch] = di; nc[ch] = 0; end
        CLR:  begin nd[ch] = 0; nc[ch] = 0; end
        SHL:  begin nd[ch] = (r * 2 + sb) % 65536; nc[ch] = r / 32768; end
        SHR:  begin nd[ch] = sb * 32768 + r / 2; nc[ch] = r % 2; end
        INC:  begin nd[ch] = (r + 1) % 65536; nc[ch] = (r == 65535) ? 1 : 0; end
        DEC:  begin nd[ch] = (r + 65535) % 65536; nc[ch] = (r == 0) ? 1 : 0; end
        CHN:  begin nd[ch] = (ch == 0) ? di : m_dout[ch-1]; nc[ch] = 0; end
        default: ;
      endcase
      if (!c_n) begin nd[ch] = 0; nc[ch] = 0; end
    end
    for (int ch = 0; ch < NC; ch++) begin
      m_dout[ch] = nd[ch];
      m_cout[ch] = nc[ch];
    end
  endtask

  task automatic drive(input logic c_n, input logic [5:0] o, input logic [31:0] d,
                       input logic [1:0] s);
    clr_n  = c_n;
    op     = o;
    din    = d;
    ser_in = s;
    model_step(c_n, o, d, s);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_dout_vec();
    return {m_dout[1][15:0], m_dout[0][15:0]};
  endfunction

  function automatic logic [1:0] m_zero_vec();
    return {m_dout[1] == 0, m_dout[0] == 0};
  endfunction

  function automatic logic [1:0] m_cout_vec();
    return {m_cout[1] != 0, m_cout[0] != 0};
  endfunction

  initial begin
    clr_n = 1'b1; op = '0; din = '0; ser_in = '0;
    for (int ch = 0; ch < NC; ch++) begin m_dout[ch] = 0; m_cout[ch] = 0; end

    // {clr_n, {op1,op0}, {din1,din0}, {ser1,ser0}, exp dout, exp zero, exp cout}
    vecs[0]  = '{1'b0, {LOAD, LOAD}, 32'hFFFF_FFFF, 2'b00, 32'h0000_0000, 2'b11, 2'b00};
    vecs[1]  = '{1'b1, {HOLD, LOAD}, 32'h0000_8001, 2'b00, 32'h0000_8001, 2'b10, 2'b00};
    vecs[2]  = '{1'b1, {HOLD, SHL},  32'h0000_0000, 2'b00, 32'h0000_0002, 2'b10, 2'b01};
    vecs[3]  = '{1'b1, {HOLD, SHR},  32'h0000_0000, 2'b01, 32'h0000_8001, 2'b10, 2'b00};
    vecs[4]  = '{1'b1, {LOAD, HOLD}, 32'hFFFF_0000, 2'b00, 32'hFFFF_8001, 2'b00, 2'b00};
    vecs[5]  = '{1'b1, {INC, HOLD},  32'h0000_0000, 2'b00, 32'h0000_8001, 2'b10, 2'b10};
    vecs[6]  = '{1'b1, {DEC, HOLD},  32'h0000_0000, 2'b00, 32'hFFFF_8001, 2'b00, 2'b10};
    vecs[7]  = '{1'b1, {HOLD, HOLD}, 32'h1234_5678, 2'b11, 32'hFFFF_8001, 2'b00, 2'b10};
    vecs[8]  = '{1'b1, {CHN, CHN},   32'h0000_1111, 2'b00, 32'h8001_1111, 2'b00, 2'b00};
    vecs[9]  = '{1'b1, {CHN, CHN},   32'h0000_2222, 2'b00, 32'h1111_2222, 2'b00, 2'b00};
    vecs[10] = '{1'b1, {CHN, CHN},   32'h0000_3333, 2'b00, 32'h2222_3333, 2'b00, 2'b00};
    vecs[11] = '{1'b1, {CLR, LOAD},  32'h0000_0005, 2'b00, 32'h0000_0005, 2'b10, 2'b00};
    vecs[12] = '{1'b1, {CLR, INC},   32'h0000_0000, 2'b00, 32'h0000_0006, 2'b10, 2'b00};
    vecs[13] = '{1'b1, {HOLD, INC},  32'h0000_0000, 2'b00, 32'h0000_0007, 2'b10, 2'b00};
    vecs[14] = '{1'b0, {HOLD, INC},  32'h0000_0000, 2'b00, 32'h0000_0000, 2'b11, 2'b00};
    vecs[15] = '{1'b1, {HOLD, INC},  32'h0000_0000, 2'b00, 32'h0000_0001, 2'b10, 2'b00};
    vecs[16] = '{1'b1, {HOLD, INC},  32'h0000_0000, 2'b00, 32'h0000_0002, 2'b10, 2'b00};
    vecs[17] = '{1'b1, {HOLD, CLR},  32'h0000_0000, 2'b00, 32'h0000_0000, 2'b11, 2'b00};
    vecs[18] = '{1'b1, {HOLD, DEC},  32'h0000_0000, 2'b00, 32'h0000_FFFF, 2'b10, 2'b01};

    @(posedge clk);
    #1;
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].clr_n, vecs[i].op, vecs[i].din, vecs[i].ser);
      chk($sformatf("vec%0d dout", i), dout, vecs[i].e_dout);
      chk($sformatf("vec%0d zero", i), {30'd0, zero}, {30'd0, vecs[i].e_zero});
      chk($sformatf("vec%0d cout", i), {30'd0, cout}, {30'd0, vecs[i].e_cout});
    end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic c_n;
      c_n = ($urandom_range(0, 63) != 0);
      drive(c_n, 6'($urandom), $urandom, 2'($urandom));
      chk($sformatf("rnd%0d dout", cyc), dout, m_dout_vec());
      chk($sformatf("rnd%0d zero", cyc), {30'd0, zero}, {30'd0, m_zero_vec()});
      chk($sformatf("rnd%0d cout", cyc), {30'd0, cout}, {30'd0, m_cout_vec()});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
